// File: rtl/db_spi_ctrl_pkg.sv
// Shared register map, status bit positions, FSM encoding and command layout
// for the settings-bus SPI master.
package db_spi_ctrl_pkg;

  localparam int SR_DIV  = 0;
  localparam int SR_CTRL = 1;
  localparam int SR_PUSH = 2;
  localparam int SR_CMD  = 3;

  localparam int RB_STATUS = 0;
  localparam int RB_CONFIG = 1;

  localparam int ST_OVF      = 63;
  localparam int ST_BUSY     = 62;
  localparam int ST_RB_NE    = 61;
  localparam int ST_CMD_FULL = 60;

  localparam int CTL_N_MSB   = 29;
  localparam int CTL_N_LSB   = 24;
  localparam int CTL_EDGE    = 31;
  localparam int CMD_POP_BIT = 0;
  localparam int OVF_CLR_BIT = 1;

  localparam logic [63:0] RB_BAD = 64'h0BADC0DE0BADC0DE;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SETUP = 3'd1,
    S_SHIFT = 3'd2,
    S_HOLD  = 3'd3,
    S_GAP   = 3'd4
  } state_t;

  typedef struct packed {
    logic [15:0] div;
    logic [31:0] ctrl;
    logic [31:0] data;
  } cmd_t;

  // A zero bit-count field encodes a full 32-bit transfer.
  function automatic logic [5:0] bit_count(input logic [5:0] field);
    return (field == 6'd0) ? 6'd32 : field;
  endfunction

endpackage

// File: rtl/db_spi_ctrl_fifo.sv
// Generic first-word-fall-through queue, 2^DEPTH entries, head visible combinationally.
// A push while full is accepted only when a pop happens in the same cycle.
module db_spi_ctrl_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic [DEPTH:0]   count,
  output logic             full,
  output logic             empty
);

  localparam int CAP = 1 << DEPTH;

  logic [WIDTH-1:0] mem [CAP];
  logic [DEPTH-1:0] wr_ptr;
  logic [DEPTH-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (DEPTH+1)'(CAP));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + (DEPTH+1)'(do_push) - (DEPTH+1)'(do_pop);
    end
  end

endmodule

// File: rtl/db_spi_ctrl.sv
// Settings-bus SPI master: queued commands carry their own divider and control,
// captured miso words land in a readback queue that stalls the engine when full.
module db_spi_ctrl
  import db_spi_ctrl_pkg::*;
#(
  parameter int                 SR_BASE   = 160,
  parameter int                 NUM_SEN   = 8,
  parameter int                 CMD_DEPTH = 4,
  parameter int                 RB_DEPTH  = 4,
  parameter logic               CLK_IDLE  = 1'b0,
  parameter logic [NUM_SEN-1:0] SEN_IDLE  = '1,
  parameter int                 RB_BASE   = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               set_stb,
  input  logic [7:0]         set_addr,
  input  logic [31:0]        set_data,
  input  logic [7:0]         rb_addr,
  output logic               rb_stb,
  output logic [63:0]        rb_data,
  output logic [NUM_SEN-1:0] sen,
  output logic               sclk,
  output logic               mosi,
  input  logic               miso,
  output logic               busy
);

  localparam logic [7:0] A_DIV    = 8'(SR_BASE + SR_DIV);
  localparam logic [7:0] A_CTRL   = 8'(SR_BASE + SR_CTRL);
  localparam logic [7:0] A_PUSH   = 8'(SR_BASE + SR_PUSH);
  localparam logic [7:0] A_CMD    = 8'(SR_BASE + SR_CMD);
  localparam logic [7:0] A_STATUS = 8'(RB_BASE + RB_STATUS);
  localparam logic [7:0] A_CONFIG = 8'(RB_BASE + RB_CONFIG);

  logic [15:0] div_q;
  logic [31:0] ctrl_q;
  logic        ovf_q;

  logic wr_div, wr_ctrl, wr_push, wr_cmd;
  assign wr_div  = set_stb && (set_addr == A_DIV);
  assign wr_ctrl = set_stb && (set_addr == A_CTRL);
  assign wr_push = set_stb && (set_addr == A_PUSH);
  assign wr_cmd  = set_stb && (set_addr == A_CMD);

  cmd_t                 cmd_in, cmd_head, cur;
  logic                 cmd_pop, cmd_full, cmd_empty;
  logic [CMD_DEPTH:0]   cmd_count;
  logic                 rb_push, rb_pop, rb_full, rb_empty;
  logic [31:0]          rb_head, shreg;
  logic [RB_DEPTH:0]    rb_count;

  assign cmd_in = '{div: div_q, ctrl: ctrl_q, data: set_data};
  assign rb_pop = wr_cmd && set_data[CMD_POP_BIT];

  db_spi_ctrl_fifo #(.WIDTH($bits(cmd_t)), .DEPTH(CMD_DEPTH)) u_cmd_fifo (
    .clk(clk), .reset(reset), .push(wr_push), .push_data(cmd_in), .pop(cmd_pop),
    .head(cmd_head), .count(cmd_count), .full(cmd_full), .empty(cmd_empty)
  );

  db_spi_ctrl_fifo #(.WIDTH(32), .DEPTH(RB_DEPTH)) u_rb_fifo (
    .clk(clk), .reset(reset), .push(rb_push), .push_data(shreg), .pop(rb_pop),
    .head(rb_head), .count(rb_count), .full(rb_full), .empty(rb_empty)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_q  <= '0;
      ctrl_q <= '0;
      ovf_q  <= 1'b0;
    end else begin
      if (wr_div)  div_q  <= set_data[15:0];
      if (wr_ctrl) ctrl_q <= set_data;
      if (wr_push && cmd_full && !cmd_pop) ovf_q <= 1'b1;
      else if (wr_cmd && set_data[OVF_CLR_BIT]) ovf_q <= 1'b0;
    end
  end

  state_t             state, state_d;
  logic [15:0]        cnt;
  logic               phase;
  logic [4:0]         bit_idx;
  logic               hp_end;
  logic [NUM_SEN-1:0] mask;

  assign hp_end = (cnt == cur.div);
  assign mask   = cur.ctrl[NUM_SEN-1:0];

  always_comb begin
    state_d = state;
    cmd_pop = 1'b0;
    rb_push = 1'b0;
    case (state)
      S_IDLE: begin
        if (!cmd_empty && !rb_full) begin
          state_d = S_SETUP;
          cmd_pop = 1'b1;
        end
      end
      S_SETUP: if (hp_end) state_d = S_SHIFT;
      S_SHIFT: if (hp_end && phase && bit_idx == 5'd0) state_d = S_HOLD;
      S_HOLD: begin
        if (hp_end) begin
          state_d = S_GAP;
          rb_push = 1'b1;
        end
      end
      S_GAP:   if (hp_end) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    sen  = SEN_IDLE;
    sclk = CLK_IDLE;
    mosi = 1'b0;
    case (state)
      S_SETUP: begin
        sen  = SEN_IDLE ^ mask;
        mosi = cur.data[bit_idx];
      end
      S_SHIFT: begin
        sen  = SEN_IDLE ^ mask;
        mosi = cur.data[bit_idx];
        sclk = phase ? ~CLK_IDLE : CLK_IDLE;
      end
      S_HOLD:  sen = SEN_IDLE ^ mask;
      default: ;
    endcase
  end

  // shreg starts cleared and shifts exactly N times, so the word is already right-aligned.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= S_IDLE;
      cnt     <= '0;
      phase   <= 1'b0;
      bit_idx <= '0;
      cur     <= '0;
      shreg   <= '0;
    end else begin
      state <= state_d;
      cnt   <= (state == S_IDLE || hp_end) ? 16'd0 : cnt + 16'd1;
      if (cmd_pop) begin
        cur     <= cmd_head;
        bit_idx <= 5'(bit_count(cmd_head.ctrl[CTL_N_MSB:CTL_N_LSB]) - 6'd1);
        phase   <= 1'b0;
        shreg   <= '0;
      end
      if (state == S_SHIFT && hp_end) begin
        phase <= ~phase;
        if (phase) bit_idx <= bit_idx - 5'd1;
        if (phase == cur.ctrl[CTL_EDGE]) shreg <= {shreg[30:0], miso};
      end
    end
  end

  assign busy   = (state != S_IDLE);
  assign rb_stb = 1'b1;

  always_comb begin
    rb_data = RB_BAD;
    if (rb_addr == A_STATUS) begin
      rb_data              = '0;
      rb_data[ST_OVF]      = ovf_q;
      rb_data[ST_BUSY]     = busy;
      rb_data[ST_RB_NE]    = !rb_empty;
      rb_data[ST_CMD_FULL] = cmd_full;
      rb_data[31:0]        = rb_empty ? 32'd0 : rb_head;
    end else if (rb_addr == A_CONFIG) begin
      rb_data = {16'd0, div_q, ctrl_q};
    end
  end

  logic unused_bits;
  assign unused_bits = ^{cur, set_data, cmd_count, rb_count};

endmodule

// File: doc/db_spi_ctrl.md
DB_SPI_CTRL -- requirements
Module: db_spi_ctrl

Interface
REQ-001 Parameters (name, default, meaning), one per line:
  SR_BASE 160 first settings-bus address; NUM_SEN 8 chip-select count (1..24); CMD_DEPTH 4 log2 command-queue depth; RB_DEPTH 4 log2 readback-queue depth; CLK_IDLE 0 idle sclk level; SEN_IDLE all-ones idle sen levels; RB_BASE 16 first readback address.
REQ-002 Ports (name, direction, width, meaning), one per line:
  clk in 1 sole clock.
  reset in 1 asynchronous active-high reset.
  set_stb in 1 settings write strobe.
  set_addr in 8 settings address.
  set_data in 32 settings data.
  rb_addr in 8 readback address.
  rb_stb out 1 readback valid.
  rb_data out 64 readback word.
  sen out NUM_SEN chip selects.
  sclk out 1 SPI clock.
  mosi out 1 SPI data out.
  miso in 1 SPI data in.
  busy out 1 transaction in progress.

Function
REQ-003 SR_BASE+0 SHALL hold divider D[15:0]; one sclk half-period = D+1 clk cycles.
REQ-004 SR_BASE+1 SHALL hold control: [NUM_SEN-1:0] select mask; [29:24] bit count N (0 means 32); [31] miso edge (0 = leading, 1 = trailing).
REQ-005 A write to SR_BASE+2 SHALL push {D, control, set_data} into the command queue (depth 2^CMD_DEPTH), so later config writes do not affect queued commands.
REQ-006 A push to a full command queue SHALL be dropped and SHALL set a sticky overflow flag.
REQ-007 A write to SR_BASE+3 SHALL do the following: bit0 = 1 pops the readback head (no-op if empty); bit1 = 1 clears overflow.
REQ-008 FSM states SHALL be IDLE, SETUP, SHIFT, HOLD, GAP.
REQ-009 IDLE -> SETUP SHALL occur only when the command queue is non-empty and the readback queue is not full; the command is popped on this transition.
REQ-010 SETUP SHALL last one half-period, with sen = SEN_IDLE ^ mask, sclk = CLK_IDLE, and mosi = bit N-1.
REQ-011 SHIFT SHALL send N bits MSB-first from data[N-1:0], each bit lasting two half-periods:
  - first half-period: sclk = CLK_IDLE, mosi valid from bit start;
  - second half-period: sclk = ~CLK_IDLE.
REQ-012 miso SHALL be sampled on the clk cycle sclk goes active (edge 0) or returns idle (edge 1), and shifted in LSB-side.
REQ-013 HOLD SHALL last one half-period with sen asserted and sclk idle.
REQ-014 On exit from HOLD, sen SHALL return to SEN_IDLE and the N captured bits SHALL be pushed right-aligned and zero-extended.
REQ-015 GAP SHALL last one half-period, then return to IDLE.
REQ-016 sen active time SHALL be (2N+2)(D+1) cycles; back-to-back transactions SHALL be separated by at least D+1 idle-sen cycles.
REQ-017 busy SHALL be high in every state except IDLE.
REQ-018 rb_stb SHALL be constant 1 (combinational readback).
REQ-019 rb_addr = RB_BASE SHALL return:
  - [63] overflow; [62] busy; [61] readback non-empty; [60] command full;
  - [59:32] zero;
  - [31:0] readback head, or 0 if empty.
REQ-020 rb_addr = RB_BASE+1 SHALL return {16'd0, D, control}; any other address SHALL return 64'h0BADC0DE0BADC0DE.
REQ-021 A simultaneous pop and push on the readback queue SHALL both take effect, leaving the count unchanged.
REQ-022 A push to the command queue in the same cycle as the FSM pop SHALL succeed when the queue is full at that cycle's start.

Reset
REQ-023 reset SHALL asynchronously force:
  - sen = SEN_IDLE, sclk = CLK_IDLE, mosi = 0, busy = 0;
  - FSM to IDLE, D = 0, control = 0, overflow = 0;
  - both queues empty.
REQ-024 A reset mid-transaction SHALL abort the transfer without pushing readback.

Structure
REQ-025 Register offsets, readback offsets, FSM encodings and the status-bit positions SHALL reside in shared package db_spi_ctrl_pkg.
REQ-026 Both queues SHALL use one sub-module, db_spi_ctrl_fifo (parametrised width and depth, async reset, count output).

Verification
REQ-027 D = 1, N = 8, mask = 0x01, data = 0xA5, miso loopback, edge 0 -> readback 0x000000A5, sen[0] low for 36 cycles, sclk period 4 cycles.
REQ-028 D = 0, N = 0, data = 0xDEADBEEF, miso tied 1 -> 32 bits sent MSB-first, readback 0xFFFFFFFF, sen active for 66 cycles.
REQ-029 17 pushes with CMD_DEPTH = 4 while the FSM is stalled (readback full) -> overflow = 1, 16 commands retained; SR_BASE+3 = 2 clears overflow.
REQ-030 Fill the readback queue (16 entries) -> FSM holds in IDLE with busy = 0; pop one entry -> next transaction starts.
REQ-031 Assert reset during SHIFT bit 3 -> sen = 0xFF and sclk = 0 immediately, readback count unchanged at 0, busy = 0.
REQ-032 Change D and mask between two queued pushes -> each transaction uses its own captured D and mask.
